// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, cin, sub in;
//   out_valid/out_ready, sum, cout out; ovf when CSA_OVERFLOW_EN is defined.
module csa_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
    localparam int BDIV = (BLOCK < 1) ? 1 : BLOCK;
    localparam int NBLK = WIDTH / BDIV;
    localparam int GB   = NBLK / SDIV;
    localparam int GW   = GB * BLOCK;
    localparam int LAST = SDIV - 1;

    if (STAGES < 1 || BLOCK < 1 || (WIDTH % BDIV) != 0 ||
        (NBLK % SDIV) != 0) begin : g_bad_cfg
        $error("csa_pipe_adder: illegal WIDTH/BLOCK/STAGES");
    end

    function automatic logic [BLOCK:0] ripple(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             c
    );
        logic [BLOCK:0] r;
        logic           cc;
        cc = c;
        r  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[BLOCK] = cc;
        return r;
    endfunction

    logic adv;

    // Whole pipe moves together; a full output stage blocks everything.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SDIV; k++) begin : g_stg
        // Operand bits already consumed are dropped from the stage register.
        localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((k + 1) * GW);

        logic [WIDTH-1:0] a_s, b_s, s_in;
        logic             c_s, v_s;
        logic [GB:0]      c_blk;
        logic [GW-1:0]    s_grp;
        logic [WIDTH-1:0] sum_d, opa_d, opb_d;
        logic             vld_d, cy_d;
        logic [WIDTH-1:0] sum_q, opa_q, opb_q;
        logic             vld_q, cy_q;

        if (k == 0) begin : g_src
            // Subtract as a + ~b + 1; cin is irrelevant then.
            assign a_s  = a;
            assign b_s  = sub ? ~b : b;
            assign c_s  = sub | cin;
            assign v_s  = in_valid;
            assign s_in = '0;
        end else begin : g_src
            assign a_s  = g_stg[k-1].opa_q;
            assign b_s  = g_stg[k-1].opb_q;
            assign c_s  = g_stg[k-1].cy_q;
            assign v_s  = g_stg[k-1].vld_q;
            assign s_in = g_stg[k-1].sum_q;
        end

        assign c_blk[0] = c_s;

        for (genvar j = 0; j < GB; j++) begin : g_blk
            localparam int LO = (k * GB + j) * BLOCK;
            logic [BLOCK:0] r;
            if (k == 0 && j == 0) begin : g_rip
                assign r = ripple(a_s[LO +: BLOCK], b_s[LO +: BLOCK],
                                  c_blk[0]);
            end else begin : g_sel
                logic [BLOCK:0] r0, r1;
                assign r0 = ripple(a_s[LO +: BLOCK], b_s[LO +: BLOCK], 1'b0);
                assign r1 = ripple(a_s[LO +: BLOCK], b_s[LO +: BLOCK], 1'b1);
                assign r  = c_blk[j] ? r1 : r0;
            end
            assign s_grp[j*BLOCK +: BLOCK] = r[BLOCK-1:0];
            assign c_blk[j+1]              = r[BLOCK];
        end

        always_comb begin
            sum_d               = s_in;
            sum_d[k*GW +: GW]   = s_grp;
        end

        assign opa_d = a_s & KEEP;
        assign opb_d = b_s & KEEP;
        assign vld_d = v_s;
        assign cy_d  = c_blk[GB];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
                opa_q <= '0;
                opb_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
        end
    end

    assign out_valid = g_stg[LAST].vld_q;
    assign sum       = g_stg[LAST].sum_q;
    assign cout      = g_stg[LAST].cy_q;

    // Final stage has no operand bits left to carry forward.
    logic unused_ops;
    assign unused_ops = ^{g_stg[LAST].opa_q, g_stg[LAST].opb_q};

`ifdef CSA_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Carry into MSB recovered as a^b^s at the MSB, then XOR carry out.
    assign ovf_d = g_stg[LAST].a_s[WIDTH-1] ^ g_stg[LAST].b_s[WIDTH-1] ^
                   g_stg[LAST].sum_d[WIDTH-1] ^ g_stg[LAST].cy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed self-checking bench for csa_pipe_adder (32/4/2).
// Covers reset, add/sub, wrap, boundaries, back-to-back, stall, mid reset.
module tb_csa_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CSA_OVERFLOW_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    csa_pipe_adder #(
        .WIDTH (32),
        .BLOCK (4),
        .STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Accept one operand set, confirm latency and the result.
    task automatic run1(input string tag, input logic [31:0] xa,
                        input logic [31:0] xb, input logic xc,
                        input logic xs, input logic [31:0] es,
                        input logic ec);
        a        = xa;
        b        = xb;
        cin      = xc;
        sub      = xs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #3;
        check("rst_vld", {63'd0, out_valid}, 64'd0);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_rdy", {63'd0, in_ready}, 64'd1);

        run1("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1);
        run1("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run1("sub75", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1);
        run1("cin1", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
             32'h2345_678A, 1'b0);
        run1("grp", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0,
             32'h0001_0000, 1'b0);
        run1("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
             32'h0, 1'b1);
        run1("subeq", 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1,
             32'h0, 1'b1);
        run1("blk", 32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0,
             32'h0000_0011, 1'b0);

        // Back-to-back accepts.
        a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1;
        check("b2b_v1", {63'd0, out_valid}, 64'd1);
        check("b2b_s1", {32'd0, sum}, 64'd2);
        a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_v2", {63'd0, out_valid}, 64'd1);
        check("b2b_s2", {32'd0, sum}, 64'd4);
        @(posedge clk);
        #1;
        check("b2b_v3", {63'd0, out_valid}, 64'd1);
        check("b2b_s3", {32'd0, sum}, 64'd6);
        @(posedge clk);
        #1;
        check("b2b_end", {63'd0, out_valid}, 64'd0);

        // Output stall: no accept, result held.
        run1("stl", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0);
        out_ready = 1'b0;
        a = 32'd100; b = 32'd1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        #1;
        check("stl_rdy0", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("stl_hv", {63'd0, out_valid}, 64'd1);
        check("stl_hs", {32'd0, sum}, 64'd30);
        @(posedge clk);
        #1;
        check("stl_hs2", {32'd0, sum}, 64'd30);
        out_ready = 1'b1;
        #1;
        check("stl_rdy1", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stl_bub", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("stl_nv", {63'd0, out_valid}, 64'd1);
        check("stl_ns", {32'd0, sum}, 64'd101);
        @(posedge clk);
        #1;
        check("stl_nodup", {63'd0, out_valid}, 64'd0);

        // Reset while a result is in flight.
        a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_vld", {63'd0, out_valid}, 64'd0);
        check("mrst_rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_v1", {63'd0, out_valid}, 64'd0);
        check("mrst_s1", {32'd0, sum}, 64'd0);
        @(posedge clk);
        #1;
        check("mrst_v2", {63'd0, out_valid}, 64'd0);
        run1("mrst_new", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0);

`ifdef CSA_OVERFLOW_EN
        run1("ovfp", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0);
        check("ovfp_ovf", {63'd0, ovf}, 64'd1);
        run1("ovfn", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b1);
        check("ovfn_ovf", {63'd0, ovf}, 64'd1);
        run1("ovf0", 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0);
        check("ovf0_ovf", {63'd0, ovf}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
CSA_PIPE_ADDER -- requirements
Module: csa_pipe_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter BLOCK, default 4, carry-select block width in bits.
REQ-003 SHALL provide parameter STAGES, default 2, number of pipeline register stages (latency).
REQ-004 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port in_valid  input  1  operands present.
REQ-007 SHALL provide port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL provide port a  input  WIDTH  operand A.
REQ-009 SHALL provide port b  input  WIDTH  operand B.
REQ-010 SHALL provide port cin  input  1  carry-in; ignored when sub=1.
REQ-011 SHALL provide port sub  input  1  mode: 0 = A+B+cin, 1 = A-B.
REQ-012 SHALL provide port out_valid  output  1  result present.
REQ-013 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-014 SHALL provide port sum  output  WIDTH  result.
REQ-015 SHALL provide port cout  output  1  carry-out of MSB (for sub: 1 = no borrow).

Function
REQ-016 Elaboration SHALL fail if WIDTH%BLOCK!=0 or (WIDTH/BLOCK)%STAGES!=0 or STAGES<1.
REQ-017 Lowest block SHALL be ripple; every other block SHALL compute cin=0 and cin=1 ripple results and select by incoming carry.
REQ-018 Stage k (0..STAGES-1) SHALL resolve block group k (WIDTH/(BLOCK*STAGES) blocks) and register: resolved low sum bits, group carry-out, unconsumed upper operand bits, valid bit.
REQ-019 sub=1 SHALL use ~b and carry-in 1, latched at acceptance; sub/cin SHALL NOT be sampled later.
REQ-020 advance = ~out_valid | out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-021 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-022 When advance=1 all stages SHALL shift one position; stage 0 loads valid=in_valid.
REQ-023 When advance=0 all stage registers, sum, cout, out_valid SHALL hold.
REQ-024 Latency SHALL be exactly STAGES cycles from accept to out_valid with no stall; throughput one result/cycle.
REQ-025 Bubbles SHALL propagate as valid=0 stages; results SHALL emerge in acceptance order, none dropped or duplicated.
REQ-026 Wrap-around: sum SHALL be modulo 2^WIDTH, carry reported only on cout.
REQ-027 sum/cout SHALL be driven from the final stage register, no combinational path from a/b.

Reset
REQ-028 rst=1 SHALL immediately clear all valid bits, out_valid=0, sum=0, cout=0, and all data registers to 0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight results; first result after rst release SHALL be the first operands accepted afterwards.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-031 With macro CSA_OVERFLOW_EN defined, SHALL add port ovf  output  1, signed overflow (carry into MSB XOR carry out of MSB), registered alongside sum, reset 0.
REQ-032 Without CSA_OVERFLOW_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32, BLOCK=4, STAGES=2)
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x00000000, cout=1.
REQ-034 a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-035 Three back-to-back accepts (1+1, 2+2, 3+3), out_ready=1 -> sums 2, 4, 6 on three consecutive cycles starting cycle 2.
REQ-036 out_ready=0 while out_valid=1 -> sum held stable, in_ready=0, no accept; out_ready=1 next cycle -> held result transfers, in_ready=1 same cycle.
REQ-037 rst pulsed one cycle after accepting 0x10+0x20 -> out_valid stays 0, sum=0; later accept 3+4 -> sum=7 after 2 cycles.
REQ-038 With CSA_OVERFLOW_EN: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0; a=0x80000000, b=1, sub=1 -> ovf=1.
